pipe_issue_ctrl: RTL and testbench

PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

---
 rtl/pipe_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_ctrl.sv
// Issue controller for a fixed-latency pipeline: a shift-register scoreboard blocks
// read-after-write hazards, instructions issue one cycle after acceptance.
module pipe_issue_ctrl #(
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_rs1_i,
  input  logic [3:0]       in_rs2_i,
  input  logic [3:0]       in_rd_i,
  input  logic [3:0]       in_func_i,
  input  logic [7:0]       in_addr_i,
  input  logic             flush_i,
  output logic             iss_valid_o,
  output logic [3:0]       iss_rs1_o,
  output logic [3:0]       iss_rs2_o,
  output logic [3:0]       iss_rd_o,
  output logic [3:0]       iss_func_o,
  output logic [7:0]       iss_addr_o,
  output logic             busy_o,
  output logic             err_func_o,
  output logic [CNT_W-1:0] issue_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [LAT-1:0]   sbValid_q, sbValid_d;
  logic [3:0]       sbRd_q [LAT];
  logic [3:0]       sbRd_d [LAT];
  logic             issValid_q, issValid_d;
  logic [3:0]       issRs1_q, issRs1_d;
  logic [3:0]       issRs2_q, issRs2_d;
  logic [3:0]       issRd_q, issRd_d;
  logic [3:0]       issFunc_q, issFunc_d;
  logic [7:0]       issAddr_q, issAddr_d;
  logic             errFunc_q, errFunc_d;
  logic [CNT_W-1:0] issueCnt_q, issueCnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic illegal, useA, useB, hazard, fire, legalFire;

  assign illegal = (in_func_i >= 4'd12);

  // Which operands a function actually reads; unused operands never cause a stall.
  always_comb begin
    useA = 1'b0;
    useB = 1'b0;
    case (in_func_i)
      4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
        useA = 1'b1;
        useB = 1'b1;
      end
      4'd3, 4'd8, 4'd10, 4'd11: useA = 1'b1;
      4'd4, 4'd9:               useB = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      if (sbValid_q[k] && ((useA && (sbRd_q[k] == in_rs1_i)) ||
                           (useB && (sbRd_q[k] == in_rs2_i))))
        hazard = 1'b1;
    end
  end

  assign in_ready_o = !flush_i && (illegal || !hazard);
  assign fire       = in_valid_i && in_ready_o;
  assign legalFire  = fire && !illegal;

  // legalFire is already low during a flush, so slot 0 and the issue strobe clear with it.
  always_comb begin
    sbValid_d    = '0;
    sbValid_d[0] = legalFire;
    sbRd_d[0]    = in_rd_i;
    for (int k = 1; k < LAT; k++) begin
      sbValid_d[k] = sbValid_q[k-1] && !flush_i;
      sbRd_d[k]    = sbRd_q[k-1];
    end

    issValid_d = legalFire;
    issRs1_d   = issRs1_q;
    issRs2_d   = issRs2_q;
    issRd_d    = issRd_q;
    issFunc_d  = issFunc_q;
    issAddr_d  = issAddr_q;
    if (legalFire) begin
      issRs1_d  = in_rs1_i;
      issRs2_d  = in_rs2_i;
      issRd_d   = in_rd_i;
      issFunc_d = in_func_i;
      issAddr_d = in_addr_i;
    end

    errFunc_d = fire && illegal;

    issueCnt_d = issueCnt_q;
    if (legalFire && (issueCnt_q != '1))
      issueCnt_d = issueCnt_q + CNT_W'(1);

    stallCnt_d = stallCnt_q;
    if (in_valid_i && !in_ready_o && (stallCnt_q != '1))
      stallCnt_d = stallCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbValid_q  <= '0;
      for (int k = 0; k < LAT; k++) sbRd_q[k] <= '0;
      issValid_q <= 1'b0;
      issRs1_q   <= '0;
      issRs2_q   <= '0;
      issRd_q    <= '0;
      issFunc_q  <= '0;
      issAddr_q  <= '0;
      errFunc_q  <= 1'b0;
      issueCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      sbValid_q  <= sbValid_d;
      for (int k = 0; k < LAT; k++) sbRd_q[k] <= sbRd_d[k];
      issValid_q <= issValid_d;
      issRs1_q   <= issRs1_d;
      issRs2_q   <= issRs2_d;
      issRd_q    <= issRd_d;
      issFunc_q  <= issFunc_d;
      issAddr_q  <= issAddr_d;
      errFunc_q  <= errFunc_d;
      issueCnt_q <= issueCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign iss_valid_o = issValid_q;
  assign iss_rs1_o   = issRs1_q;
  assign iss_rs2_o   = issRs2_q;
  assign iss_rd_o    = issRd_q;
  assign iss_func_o  = issFunc_q;
  assign iss_addr_o  = issAddr_q;
  assign err_func_o  = errFunc_q;
  assign busy_o      = issValid_q || (|sbValid_q);
  assign issue_cnt_o = issueCnt_q;
  assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison against a transfer-time-based behavioural model.
module tb_pipe_issue_ctrl;
  localparam int LAT  = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inValid = 1'b0;
  logic [3:0] inRs1 = '0, inRs2 = '0, inRd = '0, inFunc = '0;
  logic [7:0] inAddr = '0;
  logic flush = 1'b0;

  logic inReady, issValid, busy, errFunc;
  logic [3:0] issRs1, issRs2, issRd, issFunc;
  logic [7:0] issAddr;
  logic [CW-1:0] issueCnt, stallCnt;

  int nCmp = 0;
  int nFail = 0;
  bit cmpEn = 1'b0;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(inValid), .in_ready_o(inReady),
    .in_rs1_i(inRs1), .in_rs2_i(inRs2), .in_rd_i(inRd), .in_func_i(inFunc),
    .in_addr_i(inAddr), .flush_i(flush),
    .iss_valid_o(issValid), .iss_rs1_o(issRs1), .iss_rs2_o(issRs2),
    .iss_rd_o(issRd), .iss_func_o(issFunc), .iss_addr_o(issAddr),
    .busy_o(busy), .err_func_o(errFunc),
    .issue_cnt_o(issueCnt), .stall_cnt_o(stallCnt)
  );

  // Model: each legal transfer is remembered with the edge number it happened on;
  // its rd blocks readers for the LAT cycles following that edge.
  int nowE = 0;
  int qT[$];
  logic [3:0] qRd[$];
  logic mIssValid = 1'b0, mErr = 1'b0;
  logic [3:0] mRs1 = '0, mRs2 = '0, mRd = '0, mFunc = '0;
  logic [7:0] mAddr = '0;
  int mIssueCnt = 0, mStallCnt = 0;
  bit mRdy, mFire;

  function automatic bit modelReady(input logic fl, input logic [3:0] f,
                                    input logic [3:0] rs1, input logic [3:0] rs2);
    bit useA, useB, haz;
    if (fl) return 1'b0;
    if (f >= 12) return 1'b1;
    useA = f inside {0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
    useB = f inside {0, 1, 2, 4, 5, 6, 7, 9};
    haz = 1'b0;
    foreach (qT[i]) begin
      if (nowE - qT[i] < LAT) begin
        if (useA && qRd[i] == rs1) haz = 1'b1;
        if (useB && qRd[i] == rs2) haz = 1'b1;
      end
    end
    return !haz;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nowE = 0;
      qT.delete();
      qRd.delete();
      mIssValid = 1'b0; mErr = 1'b0;
      mRs1 = '0; mRs2 = '0; mRd = '0; mFunc = '0; mAddr = '0;
      mIssueCnt = 0; mStallCnt = 0;
    end else begin
      mRdy  = modelReady(flush, inFunc, inRs1, inRs2);
      mFire = inValid && mRdy;
      mErr  = mFire && (inFunc >= 12);
      mIssValid = mFire && (inFunc < 12);
      if (mIssValid) begin
        mRs1 = inRs1; mRs2 = inRs2; mRd = inRd; mFunc = inFunc; mAddr = inAddr;
        if (mIssueCnt < CMAX) mIssueCnt++;
      end
      if (inValid && !mRdy && mStallCnt < CMAX) mStallCnt++;
      nowE++;
      if (flush) begin
        qT.delete();
        qRd.delete();
      end else if (mIssValid) begin
        qT.push_back(nowE);
        qRd.push_back(inRd);
      end
      while (qT.size() > 0 && nowE - qT[0] >= LAT) begin
        void'(qT.pop_front());
        void'(qRd.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: inputs change at posedge+2, so the falling edge sees everything settled.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("m_inReady",  inReady,  modelReady(flush, inFunc, inRs1, inRs2));
      checkOutput("m_issValid", issValid, mIssValid);
      checkOutput("m_issRs1",   issRs1,   mRs1);
      checkOutput("m_issRs2",   issRs2,   mRs2);
      checkOutput("m_issRd",    issRd,    mRd);
      checkOutput("m_issFunc",  issFunc,  mFunc);
      checkOutput("m_issAddr",  issAddr,  mAddr);
      checkOutput("m_errFunc",  errFunc,  mErr);
      checkOutput("m_busy",     busy,     mIssValid || (qT.size() > 0));
      checkOutput("m_issueCnt", issueCnt, mIssueCnt);
      checkOutput("m_stallCnt", stallCnt, mStallCnt);
    end
  end

  // One call drives one cycle: set inputs, sample in_ready, step past the next edge.
  task automatic applyStimulus(input logic v, input logic [3:0] f, input logic [3:0] rs1,
                               input logic [3:0] rs2, input logic [3:0] rd,
                               input logic [7:0] a, input logic fl, output logic rdy);
    inValid = v; inFunc = f; inRs1 = rs1; inRs2 = rs2; inRd = rd; inAddr = a; flush = fl;
    #1;
    rdy = inReady;
    @(posedge clk);
    #2;
  endtask

  task automatic holdUntilAccepted(input logic [3:0] f, input logic [3:0] rs1,
                                   input logic [3:0] rs2, input logic [3:0] rd,
                                   input logic [7:0] a, output int stalls, output logic acc);
    logic r;
    stalls = 0;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      applyStimulus(1'b1, f, rs1, rs2, rd, a, 1'b0, r);
      if (r) acc = 1'b1;
      else stalls++;
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    inValid = 1'b0; inFunc = '0; inRs1 = '0; inRs2 = '0; inRd = '0; inAddr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic r;
    logic acc;
    int stalls;

    $display("[TB] start LAT=%0d CNT_W=%0d", LAT, CW);
    resetDut();
    cmpEn = 1'b1;
    checkOutput("rst_issValid", issValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_issueCnt", issueCnt, 0);
    checkOutput("rst_inReady", inReady, 1);

    // Independent stream, one issue per cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd0, 4'd1, 4'd2, 4'(3 + i), 8'(8'h10 + i), 1'b0, r);
      checkOutput("ind_ready", r, 1);
      checkOutput("ind_issValid", issValid, 1);
      checkOutput("ind_issRd", issRd, 3 + i);
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h0, 1'b0, r);
    checkOutput("ind_idleIssValid", issValid, 0);
    checkOutput("ind_issueCnt", issueCnt, 5);
    checkOutput("ind_stallCnt", stallCnt, 0);

    // Read-after-write stall.
    resetDut();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 8'h20, 1'b0, r);
    holdUntilAccepted(4'd0, 4'd5, 4'd0, 4'd7, 8'h21, stalls, acc);
    checkOutput("raw_accepted", acc, 1);
    checkOutput("raw_stalls", stalls, 3);
    checkOutput("raw_issValid", issValid, 1);
    checkOutput("raw_issRs1", issRs1, 5);
    checkOutput("raw_issRd", issRd, 7);
    checkOutput("raw_stallCnt", stallCnt, 3);
    checkOutput("raw_issueCnt", issueCnt, 2);

    // Operand masking and write-after-write.
    resetDut();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd6, 8'h30, 1'b0, r);
    applyStimulus(1'b1, 4'd3, 4'd1, 4'd6, 4'd6, 8'h31, 1'b0, r);
    checkOutput("mask_aOnlyReady", r, 1);
    checkOutput("mask_aOnlyIssFunc", issFunc, 3);
    repeat (4) applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h0, 1'b0, r);
    checkOutput("mask_drainedBusy", busy, 0);
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd6, 8'h32, 1'b0, r);
    holdUntilAccepted(4'd4, 4'd0, 4'd6, 4'd8, 8'h33, stalls, acc);
    checkOutput("mask_bOnlyAccepted", acc, 1);
    checkOutput("mask_bOnlyStalls", stalls, 3);
    checkOutput("mask_stallCnt", stallCnt, 3);

    // Illegal function under a hazard.
    resetDut();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 8'h40, 1'b0, r);
    applyStimulus(1'b1, 4'd13, 4'd5, 4'd5, 4'd1, 8'h41, 1'b0, r);
    checkOutput("ill_ready", r, 1);
    checkOutput("ill_errFunc", errFunc, 1);
    checkOutput("ill_issValid", issValid, 0);
    checkOutput("ill_issueCnt", issueCnt, 1);
    checkOutput("ill_issAddr", issAddr, 8'h40);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h0, 1'b0, r);
    checkOutput("ill_errPulseEnd", errFunc, 0);

    // Flush over a pending reader.
    resetDut();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd9, 8'h50, 1'b0, r);
    checkOutput("fl_preBusy", busy, 1);
    applyStimulus(1'b1, 4'd0, 4'd9, 4'd0, 4'd2, 8'h51, 1'b1, r);
    checkOutput("fl_flushReady", r, 0);
    checkOutput("fl_busyAfter", busy, 0);
    checkOutput("fl_issValidAfter", issValid, 0);
    applyStimulus(1'b1, 4'd0, 4'd9, 4'd0, 4'd2, 8'h51, 1'b0, r);
    checkOutput("fl_postReady", r, 1);
    checkOutput("fl_issRs1", issRs1, 9);
    checkOutput("fl_stallCnt", stallCnt, 1);
    checkOutput("fl_issueCnt", issueCnt, 2);

    // Reset in the middle of a stall.
    resetDut();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 8'h60, 1'b0, r);
    applyStimulus(1'b1, 4'd0, 4'd5, 4'd0, 4'd7, 8'h61, 1'b0, r);
    checkOutput("rs_stallReady", r, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_issValid", issValid, 0);
    checkOutput("rs_issRd", issRd, 0);
    checkOutput("rs_busy", busy, 0);
    checkOutput("rs_issueCnt", issueCnt, 0);
    checkOutput("rs_stallCnt", stallCnt, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd0, 4'd5, 4'd0, 4'd7, 8'h61, 1'b0, r);
    checkOutput("rs_firstReady", r, 1);
    checkOutput("rs_issValidPost", issValid, 1);
    checkOutput("rs_issueCntPost", issueCnt, 1);

    // Counter saturation.
    resetDut();
    for (int i = 0; i < 18; i++)
      applyStimulus(1'b1, 4'd0, 4'd1, 4'd2, 4'(3 + (i % 10)), 8'(i), 1'b0, r);
    checkOutput("sat_issueCnt", issueCnt, CMAX);
    for (int i = 0; i < 18; i++)
      applyStimulus(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 8'h0, 1'b1, r);
    checkOutput("sat_stallCnt", stallCnt, CMAX);
    checkOutput("sat_issueCntHeld", issueCnt, CMAX);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h0, 1'b0, r);
    checkOutput("sat_busy", busy, 0);

    cmpEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
